// File: rtl/led64_frame_sched.sv
// led64_frame_sched
// Scan-timing generator and four-source frame arbiter for the 8x8 LED
// matrix scanner. The divider produces scanclk. The arbiter picks which
// 64-bit source frame is presented on d. All arbitration state changes only
// on the frame boundary, which is the scanclk fall that ends row 7. d is
// therefore settled one half-period before the scanner's row-0 load rise.
module led64_frame_sched #(
   parameter int SCAN_DIV     = 1200,
   parameter int DWELL_FRAMES = 64
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [255:0] frames_in,
   input  logic [3:0]   req,
   input  logic         manual_en,
   input  logic [1:0]   manual_sel,
   output logic         scanclk,
   output logic [63:0]  d,
   output logic [1:0]   cur_src,
   output logic         blank,
   output logic         frame_start,
   output logic [2:0]   row_idx
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DWL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [DWL_W-1:0] DWELL_LAST = DWL_W'(DWELL_FRAMES - 1);

   // Timing state
   logic [DIV_W-1:0] r_div;
   logic             r_scanclk;
   logic [2:0]       r_row;

   // Arbitration state
   logic [DWL_W-1:0] r_dwell;
   logic [1:0]       r_cur;
   logic             r_blank;
   logic [63:0]      r_d;
   logic             r_fs;

   // Decode of the divider and boundary events
   logic             w_tick;
   logic             w_rise;
   logic             w_bound;

   // Round-robin search results
   logic [1:0]       w_cand;
   logic [1:0]       w_win;
   logic             w_any;
   logic             w_keep;

   // Next arbitration state
   logic [1:0]       w_nxt_cur;
   logic             w_nxt_blank;
   logic [63:0]      w_nxt_d;
   logic [DWL_W-1:0] w_nxt_dwell;

   // Extract source i from the packed frame bus.
   function automatic logic [63:0] sel_frame(input logic [255:0] f,
                                             input logic [1:0]   i);
      return f[{i, 6'b000000} +: 64];
   endfunction

   // The divider wraps on the last count. The scanclk level before the
   // toggle tells a rise from a fall. A fall while row_idx is 0 ends row 7,
   // and that fall is the frame boundary.
   assign w_tick  = (r_div == DIV_LAST);
   assign w_rise  = w_tick & ~r_scanclk;
   assign w_bound = w_tick &  r_scanclk & (r_row == 3'd0);

   // Divider, scanclk toggle and row counter that advances on each rise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_div     <= '0;
         r_scanclk <= 1'b0;
         r_row     <= 3'd0;
      end else begin
         if (w_tick) begin
            r_div     <= '0;
            r_scanclk <= ~r_scanclk;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
         if (w_rise) begin
            r_row <= r_row + 3'd1;
         end
      end
   end

   // Round-robin search starting after the current source and ending on
   // the current source itself. The loop runs from the last candidate to
   // the first, so the earliest requester in the order overwrites later
   // ones.
   always_comb begin
      w_win  = r_cur;
      w_any  = 1'b0;
      w_cand = r_cur;
      for (int k = 4; k >= 1; k--) begin
         w_cand = r_cur + 2'(k);
         if (req[w_cand]) begin
            w_win = w_cand;
            w_any = 1'b1;
         end
      end
   end

   // The current source stays while it still requests, is actually shown,
   // and has not used up its dwell.
   assign w_keep = req[r_cur] & ~r_blank & (r_dwell < DWELL_LAST);

   // Boundary decision: manual overrides, then keep, then reselect or blank
   always_comb begin
      w_nxt_cur   = r_cur;
      w_nxt_blank = r_blank;
      w_nxt_d     = r_d;
      w_nxt_dwell = r_dwell;
      if (manual_en) begin
         w_nxt_cur   = manual_sel;
         w_nxt_blank = 1'b0;
         w_nxt_d     = sel_frame(frames_in, manual_sel);
         w_nxt_dwell = '0;
      end else if (w_keep) begin
         w_nxt_d     = sel_frame(frames_in, r_cur);
         w_nxt_dwell = r_dwell + DWL_W'(1);
      end else if (w_any) begin
         w_nxt_cur   = w_win;
         w_nxt_blank = 1'b0;
         w_nxt_d     = sel_frame(frames_in, w_win);
         w_nxt_dwell = '0;
      end else begin
         w_nxt_blank = 1'b1;
         w_nxt_d     = '0;
         w_nxt_dwell = '0;
      end
   end

   // Arbitration registers load only at the frame boundary, so they cannot tear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cur   <= 2'd0;
         r_blank <= 1'b1;
         r_d     <= '0;
         r_dwell <= '0;
      end else if (w_bound) begin
         r_cur   <= w_nxt_cur;
         r_blank <= w_nxt_blank;
         r_d     <= w_nxt_d;
         r_dwell <= w_nxt_dwell;
      end
   end

   // frame_start is high for the one cycle after the boundary edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fs <= 1'b0;
      end else begin
         r_fs <= w_bound;
      end
   end

   assign scanclk     = r_scanclk;
   assign row_idx     = r_row;
   assign d           = r_d;
   assign cur_src     = r_cur;
   assign blank       = r_blank;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_led64_frame_sched.sv
// Directed bench for led64_frame_sched with SCAN_DIV=4 and DWELL_FRAMES=2.
// A frame lasts 64 clocks. "clk n" is the nth rising edge after resetn is
// released. Outputs are sampled on the following falling edge.
module tb_led64_frame_sched;

   localparam logic [63:0] F0 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] F1 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] F2 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] F3 = 64'h4444_4444_4444_4444;
   localparam logic [63:0] FX = 64'hFF00_FF00_FF00_FF00;

   logic         clk;
   logic         resetn;
   logic [255:0] frames_in;
   logic [3:0]   req;
   logic         manual_en;
   logic [1:0]   manual_sel;
   logic         scanclk;
   logic [63:0]  d;
   logic [1:0]   cur_src;
   logic         blank;
   logic         frame_start;
   logic [2:0]   row_idx;

   int cyc;
   int total;
   int bad;

   led64_frame_sched #(.SCAN_DIV(4), .DWELL_FRAMES(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .frames_in   (frames_in),
      .req         (req),
      .manual_en   (manual_en),
      .manual_sel  (manual_sel),
      .scanclk     (scanclk),
      .d           (d),
      .cur_src     (cur_src),
      .blank       (blank),
      .frame_start (frame_start),
      .row_idx     (row_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of rising edges since reset release
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Advance to the falling edge that follows clk n
   task automatic goto(input int n);
      int guard;
      guard = 0;
      while (cyc < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (cyc !== n) begin
         bad++;
         $display("FAIL goto got=%0d exp=%0d", cyc, n);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn     = 1'b0;
      req        = 4'b0000;
      manual_en  = 1'b0;
      manual_sel = 2'd0;
      frames_in  = {F3, F2, F1, F0};
      repeat (3) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      int t;
      logic       exp_sc;
      logic [2:0] exp_row;
      logic       exp_fs;
      @(negedge clk);
      resetn    = 1'b0;
      req       = 4'b0000;
      manual_en = 1'b0;
      frames_in = {F3, F2, F1, F0};
      #1;
      total++;
      if ({scanclk, d, cur_src, blank, frame_start, row_idx} !== {1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 3'd0}) begin
         bad++;
         $display("FAIL reset_vals got=%b/%h/%0d/%b/%b/%0d exp=0/0/0/1/0/0",
                  scanclk, d, cur_src, blank, frame_start, row_idx);
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         goto(n);
         t       = n / 4;
         exp_sc  = t[0];
         exp_row = 3'(((t + 1) / 2) % 8);
         exp_fs  = (n % 64 == 0);
         total++;
         if (scanclk !== exp_sc) begin
            bad++;
            $display("FAIL idle_scanclk n=%0d got=%b exp=%b", n, scanclk, exp_sc);
         end
         total++;
         if (row_idx !== exp_row) begin
            bad++;
            $display("FAIL idle_row n=%0d got=%0d exp=%0d", n, row_idx, exp_row);
         end
         total++;
         if (frame_start !== exp_fs) begin
            bad++;
            $display("FAIL idle_fs n=%0d got=%b exp=%b", n, frame_start, exp_fs);
         end
         total++;
         if (blank !== 1'b1 || d !== 64'h0) begin
            bad++;
            $display("FAIL idle_blank n=%0d got=%b/%h exp=1/0", n, blank, d);
         end
      end
   endtask

   // Only src0 requests for the first frame, so src0 is granted from the
   // reset cur_src=0. Then src0 and src2 both request and alternate every
   // two frames.
   task automatic test_rotate();
      do_reset();
      req = 4'b0001;
      goto(64);
      total++;
      if (cur_src !== 2'd0 || blank !== 1'b0 || d !== F0) begin
         bad++;
         $display("FAIL rot_64 got=%0d/%b/%h exp=0/0/%h", cur_src, blank, d, F0);
      end
      req = 4'b0101;
      goto(128);
      total++;
      if (cur_src !== 2'd0 || d !== F0) begin
         bad++;
         $display("FAIL rot_128 got=%0d/%h exp=0/%h", cur_src, d, F0);
      end
      goto(191);
      total++;
      if (cur_src !== 2'd0) begin
         bad++;
         $display("FAIL rot_191 got=%0d exp=0", cur_src);
      end
      goto(192);
      total++;
      if (cur_src !== 2'd2 || d !== F2 || blank !== 1'b0) begin
         bad++;
         $display("FAIL rot_192 got=%0d/%h exp=2/%h", cur_src, d, F2);
      end
      goto(256);
      total++;
      if (cur_src !== 2'd2) begin
         bad++;
         $display("FAIL rot_256 got=%0d exp=2", cur_src);
      end
      goto(320);
      total++;
      if (cur_src !== 2'd0 || d !== F0) begin
         bad++;
         $display("FAIL rot_320 got=%0d/%h exp=0/%h", cur_src, d, F0);
      end
   endtask

   task automatic test_refresh();
      do_reset();
      req = 4'b0001;
      goto(64);
      total++;
      if (d !== F0) begin
         bad++;
         $display("FAIL ref_64 got=%h exp=%h", d, F0);
      end
      goto(100);
      frames_in[63:0] = FX;
      goto(127);
      total++;
      if (d !== F0) begin
         bad++;
         $display("FAIL ref_127 got=%h exp=%h", d, F0);
      end
      goto(128);
      total++;
      if (d !== FX || cur_src !== 2'd0 || frame_start !== 1'b1) begin
         bad++;
         $display("FAIL ref_128 got=%h/%0d/%b exp=%h/0/1", d, cur_src, frame_start, FX);
      end
   endtask

   task automatic test_drop();
      do_reset();
      req = 4'b0001;
      goto(64);
      total++;
      if (blank !== 1'b0 || cur_src !== 2'd0) begin
         bad++;
         $display("FAIL drop_64 got=%b/%0d exp=0/0", blank, cur_src);
      end
      goto(90);
      req = 4'b0000;
      goto(127);
      total++;
      if (blank !== 1'b0 || d !== F0) begin
         bad++;
         $display("FAIL drop_127 got=%b/%h exp=0/%h", blank, d, F0);
      end
      goto(128);
      total++;
      if (blank !== 1'b1 || d !== 64'h0 || cur_src !== 2'd0) begin
         bad++;
         $display("FAIL drop_128 got=%b/%h/%0d exp=1/0/0", blank, d, cur_src);
      end
      req = 4'b0001;
      goto(192);
      total++;
      if (blank !== 1'b0 || cur_src !== 2'd0 || d !== F0) begin
         bad++;
         $display("FAIL drop_192 got=%b/%0d/%h exp=0/0/%h", blank, cur_src, d, F0);
      end
   endtask

   task automatic test_manual();
      do_reset();
      manual_en  = 1'b1;
      manual_sel = 2'd3;
      goto(64);
      total++;
      if (cur_src !== 2'd3 || blank !== 1'b0 || d !== F3) begin
         bad++;
         $display("FAIL man_64 got=%0d/%b/%h exp=3/0/%h", cur_src, blank, d, F3);
      end
      manual_en = 1'b0;
      req       = 4'b0010;
      goto(127);
      total++;
      if (cur_src !== 2'd3) begin
         bad++;
         $display("FAIL man_127 got=%0d exp=3", cur_src);
      end
      goto(128);
      total++;
      if (cur_src !== 2'd1 || d !== F1 || blank !== 1'b0) begin
         bad++;
         $display("FAIL man_128 got=%0d/%h exp=1/%h", cur_src, d, F1);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0001;
      goto(150);
      total++;
      if (blank !== 1'b0 || scanclk !== 1'b1 || row_idx !== 3'd3) begin
         bad++;
         $display("FAIL ar_pre got=%b/%b/%0d exp=0/1/3", blank, scanclk, row_idx);
      end
      resetn = 1'b0;
      #1;
      total++;
      if ({scanclk, d, cur_src, blank, frame_start, row_idx} !== {1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 3'd0}) begin
         bad++;
         $display("FAIL ar_async got=%b/%h/%0d/%b/%b/%0d exp=0/0/0/1/0/0",
                  scanclk, d, cur_src, blank, frame_start, row_idx);
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      goto(63);
      total++;
      if (frame_start !== 1'b0 || blank !== 1'b1) begin
         bad++;
         $display("FAIL ar_63 got=%b/%b exp=0/1", frame_start, blank);
      end
      goto(64);
      total++;
      if (frame_start !== 1'b1 || blank !== 1'b0 || cur_src !== 2'd0) begin
         bad++;
         $display("FAIL ar_64 got=%b/%b/%0d exp=1/0/0", frame_start, blank, cur_src);
      end
      goto(65);
      total++;
      if (frame_start !== 1'b0) begin
         bad++;
         $display("FAIL ar_65 got=%b exp=0", frame_start);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      resetn     = 1'b0;
      req        = 4'b0000;
      manual_en  = 1'b0;
      manual_sel = 2'd0;
      frames_in  = {F3, F2, F1, F0};
      test_reset();
      test_rotate();
      test_refresh();
      test_drop();
      test_manual();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
